mem_transfer_block: RTL and testbench

Two-memory transfer engine: captures a frame of eight 8-bit samples from a free-running input stream into local memory A, then reduces adjacent pairs into a four-entry memory B (B[k] = A[2k] + A[2k+1]). Each stored result is presented on a registered output with a one-cycle valid strobe. It sits between a sample source with no flow control and a downstream consumer. It repeats frame after frame indefinitely.

---
 rtl/mem_transfer_block_pkg.sv | 26 ++
 rtl/mem_transfer_block_simple_ram.sv | 33 +++
 rtl/mem_transfer_block.sv | 131 +++++++++++++
 tb/tb_mem_transfer_block.sv | 135 +++++++++++++
 4 files changed

// File: rtl/mem_transfer_block_pkg.sv
// Shared types and constants for the two-memory frame transfer engine.
// Holds the FSM state encoding, default widths and the address-width helper.
package mem_transfer_block_pkg;

    typedef enum logic {
        WRITE_A  = 1'b0,
        TRANSFER = 1'b1
    } state_e;

    localparam int DEF_DATA_W = 8;
    localparam int SUM_W      = DEF_DATA_W + 1;

    // Address width for a memory of the given depth; never narrower than one bit.
    function automatic int addrWidth(input int depth);
        int w;
        w = 0;
        while ((1 << w) < depth) begin
            w = w + 1;
        end
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mem_transfer_block_simple_ram.sv
// Small register-file memory: one synchronous write port, one combinational
// read port, and an asynchronous active-low clear of every word.
module simple_ram
    import mem_transfer_block_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_W,
    parameter int DEPTH = 8,
    parameter int AW    = addrWidth(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_transfer_block.sv
// Frame capture into memory A, then pairwise reduction into memory B with
// each sum presented on a registered output alongside a one-cycle strobe.
module mem_transfer_block
    import mem_transfer_block_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int A_DEPTH = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [DATA_W-1:0]                   dataInA,
    output logic [DATA_W:0]                     dataOutB,
    output logic [addrWidth(A_DEPTH/2)-1:0]     addrB,
    output logic                                validB,
    output logic                                busy
);

    localparam int B_DEPTH = A_DEPTH / 2;
    localparam int A_AW    = addrWidth(A_DEPTH);
    localparam int B_AW    = addrWidth(B_DEPTH);
    localparam int OUT_W   = DATA_W + 1;

    localparam logic [A_AW-1:0] A_LAST = A_AW'(A_DEPTH - 1);
    localparam logic [B_AW-1:0] B_LAST = B_AW'(B_DEPTH - 1);

    state_e            state_q;
    state_e            state_d;
    logic [A_AW-1:0]   wrA_q;
    logic [B_AW-1:0]   k_q;
    logic              phase_q;
    logic [DATA_W-1:0] acc_q;
    logic [OUT_W-1:0]  dataOutB_q;
    logic [B_AW-1:0]   addrB_q;
    logic              validB_q;
    logic              busy_q;

    logic              lastA;
    logic              lastPair;
    logic              ramAWe;
    logic              ramBWe;
    logic [A_AW-1:0]   ramARdAddr;
    logic [DATA_W-1:0] ramARd;
    logic [OUT_W-1:0]  pairSum;
    logic [OUT_W-1:0]  ramBRdUnused;

    assign lastA      = (wrA_q == A_LAST);
    assign lastPair   = phase_q && (k_q == B_LAST);
    assign ramAWe     = (state_q == WRITE_A);
    assign ramBWe     = (state_q == TRANSFER) && phase_q;
    assign ramARdAddr = A_AW'({k_q, phase_q});
    assign pairSum    = OUT_W'(acc_q) + OUT_W'(ramARd);

    always_comb begin
        state_d = state_q;
        case (state_q)
            WRITE_A:  if (lastA)    state_d = TRANSFER;
            TRANSFER: if (lastPair) state_d = WRITE_A;
            default:  state_d = WRITE_A;
        endcase
    end

    simple_ram #(
        .WIDTH (DATA_W),
        .DEPTH (A_DEPTH),
        .AW    (A_AW)
    ) u_ramA (
        .clk_i   (clk),
        .rst_ni  (rst),
        .we_i    (ramAWe),
        .waddr_i (wrA_q),
        .wdata_i (dataInA),
        .raddr_i (ramARdAddr),
        .rdata_o (ramARd)
    );

    // Memory B is only ever written; its read port is tied off.
    simple_ram #(
        .WIDTH (OUT_W),
        .DEPTH (B_DEPTH),
        .AW    (B_AW)
    ) u_ramB (
        .clk_i   (clk),
        .rst_ni  (rst),
        .we_i    (ramBWe),
        .waddr_i (k_q),
        .wdata_i (pairSum),
        .raddr_i (k_q),
        .rdata_o (ramBRdUnused)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= WRITE_A;
            wrA_q      <= '0;
            k_q        <= '0;
            phase_q    <= 1'b0;
            acc_q      <= '0;
            dataOutB_q <= '0;
            addrB_q    <= '0;
            validB_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= (state_d == TRANSFER);
            validB_q <= 1'b0;
            case (state_q)
                WRITE_A: begin
                    wrA_q <= lastA ? '0 : wrA_q + 1'b1;
                end
                TRANSFER: begin
                    phase_q <= ~phase_q;
                    if (!phase_q) begin
                        acc_q <= ramARd;
                    end else begin
                        dataOutB_q <= pairSum;
                        addrB_q    <= k_q;
                        validB_q   <= 1'b1;
                        k_q        <= lastPair ? '0 : k_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dataOutB = dataOutB_q;
    assign addrB    = addrB_q;
    assign validB   = validB_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_mem_transfer_block.sv
// Directed bench for mem_transfer_block: reset, ramp/streaming, overflow,
// ignored transfer-time input and an asynchronous reset mid-transfer.
module tb_mem_transfer_block;

    logic       clk;
    logic       rst;
    logic [7:0] dataInA;
    logic [8:0] dataOutB;
    logic [1:0] addrB;
    logic       validB;
    logic       busy;

    int checkCount;
    int errorCount;

    logic [7:0] samp   [16];
    logic [8:0] expSum [4];

    mem_transfer_block dut (
        .clk      (clk),
        .rst      (rst),
        .dataInA  (dataInA),
        .dataOutB (dataOutB),
        .addrB    (addrB),
        .validB   (validB),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drives one 16-edge frame starting from a negedge; checks after every edge.
    task automatic applyStimulus(input string name, input logic [7:0] s [16],
                                 input logic [8:0] sums [4]);
        for (int e = 1; e <= 16; e++) begin
            dataInA = s[e-1];
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("%s/e%0d/busy", name, e), 32'(busy),
                        32'((e >= 8) && (e <= 15)));
            checkOutput($sformatf("%s/e%0d/validB", name, e), 32'(validB),
                        32'((e >= 10) && (e % 2 == 0)));
            if ((e >= 10) && (e % 2 == 0)) begin
                checkOutput($sformatf("%s/e%0d/dataOutB", name, e), 32'(dataOutB),
                            32'(sums[(e-10)/2]));
                checkOutput($sformatf("%s/e%0d/addrB", name, e), 32'(addrB),
                            32'((e-10)/2));
            end
        end
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst        = 1'b0;
        dataInA    = '0;

        // Reset held low with random input.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            dataInA = 8'($urandom_range(0, 255));
            checkOutput($sformatf("rst/c%0d/validB", i), 32'(validB), 32'd0);
            checkOutput($sformatf("rst/c%0d/dataOutB", i), 32'(dataOutB), 32'd0);
            checkOutput($sformatf("rst/c%0d/addrB", i), 32'(addrB), 32'd0);
            checkOutput($sformatf("rst/c%0d/busy", i), 32'(busy), 32'd0);
        end
        rst = 1'b1;

        // Streaming: three back-to-back frames of a continuous ramp from 1.
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 16; i++) begin
                samp[i] = 8'(f * 16 + i + 1);
            end
            case (f)
                0: expSum = '{9'd3,  9'd7,  9'd11, 9'd15};
                1: expSum = '{9'd35, 9'd39, 9'd43, 9'd47};
                default: expSum = '{9'd67, 9'd71, 9'd75, 9'd79};
            endcase
            applyStimulus($sformatf("stream%0d", f), samp, expSum);
        end

        // Ignored input: 99 driven throughout transfer.
        samp   = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd1, 8'd2, 8'd3, 8'd4,
                   8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99};
        expSum = '{9'd11, 9'd15, 9'd3, 9'd7};
        applyStimulus("ignore", samp, expSum);

        // Overflow: 9-bit sums, first sample lands on edge 17 after the 99s.
        samp   = '{8'd255, 8'd255, 8'd0, 8'd1, 8'd128, 8'd128, 8'd255, 8'd0,
                   8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99};
        expSum = '{9'd510, 9'd1, 9'd256, 9'd255};
        applyStimulus("overflow", samp, expSum);

        // Reset between edges 12 and 13 of a frame.
        for (int e = 1; e <= 12; e++) begin
            dataInA = 8'(e + 40);
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput("midrst/pre/validB", 32'(validB), 32'd1);
        checkOutput("midrst/pre/dataOutB", 32'(dataOutB), 32'd87);
        rst = 1'b0;
        #1;
        checkOutput("midrst/async/validB", 32'(validB), 32'd0);
        checkOutput("midrst/async/dataOutB", 32'(dataOutB), 32'd0);
        checkOutput("midrst/async/addrB", 32'(addrB), 32'd0);
        checkOutput("midrst/async/busy", 32'(busy), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput($sformatf("midrst/hold%0d/busy", i), 32'(busy), 32'd0);
            checkOutput($sformatf("midrst/hold%0d/validB", i), 32'(validB), 32'd0);
        end
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            samp[i] = (i < 8) ? 8'(i + 10) : 8'd0;
        end
        expSum = '{9'd21, 9'd25, 9'd29, 9'd33};
        applyStimulus("afterrst", samp, expSum);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
